// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdc_pkg
// Purpose  : Shared types and helper functions for the TDC thermometer
//            decoder: output-stage state encoding, popcount and bubble test.
// Revision : 1.0 - initial release
// ============================================================================
package tdc_pkg;

  // The helper functions work on a fixed-width word. Callers zero-extend
  // their thermometer word into it and pass the real width.
  localparam int THERM_MAX_W = 64;
  localparam int THERM_CNT_W = 7;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Number of set bits among the low `width` bits of `word`.
  function automatic logic [THERM_CNT_W-1:0] therm_count(
    input logic [THERM_MAX_W-1:0] word,
    input int                     width
  );
    logic [THERM_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < THERM_MAX_W; i++) begin
      if ((i < width) && word[i]) begin
        cnt = cnt + THERM_CNT_W'(1);
      end
    end
    return cnt;
  endfunction

  // A stage that fired while the stage before it did not fire means that
  // the word is not a clean thermometer code.
  function automatic logic therm_bubble(
    input logic [THERM_MAX_W-1:0] word,
    input int                     width
  );
    logic bub;
    bub = 1'b0;
    for (int i = 1; i < THERM_MAX_W; i++) begin
      if ((i < width) && word[i] && !word[i-1]) begin
        bub = 1'b1;
      end
    end
    return bub;
  endfunction

endpackage : tdc_pkg
`default_nettype wire

// File: rtl/tdc_thermo_count.sv
`default_nettype none
// ============================================================================
// Module   : tdc_thermo_count
// Purpose  : Combinational popcount and bubble detection on a captured
//            thermometer word. Holds no state.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_thermo_count
  import tdc_pkg::*;
#(
  parameter int NUM_STAGES = 10,
  parameter int CNT_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [NUM_STAGES-1:0] word,
  output logic [CNT_W-1:0]      count,
  output logic                  bubble
);

  logic [THERM_MAX_W-1:0] w_word;
  logic [THERM_CNT_W-1:0] w_count_full;
  logic                   w_unused_count_hi;

  // Zero padding above NUM_STAGES adds no set bits and creates no bubble.
  assign w_word       = THERM_MAX_W'(word);
  assign w_count_full = therm_count(w_word, NUM_STAGES);
  assign bubble       = therm_bubble(w_word, NUM_STAGES);

  // A count of at most NUM_STAGES always fits in CNT_W bits.
  assign count             = w_count_full[CNT_W-1:0];
  assign w_unused_count_hi = ^w_count_full[THERM_CNT_W-1:CNT_W];

endmodule : tdc_thermo_count
`default_nettype wire

// File: rtl/tdc_thermo_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tdc_thermo_decoder
// Purpose  : Captures TDC thermometer words, converts them to stage counts,
//            flags bubble codes, and averages 2**AVG_LOG2 samples. Each
//            result is offered on a one-deep valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_thermo_decoder
  import tdc_pkg::*;
#(
  parameter int NUM_STAGES = 10,
  parameter int AVG_LOG2   = 2,
  parameter int CNT_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] stage_delays,
  input  logic                  sample_valid,
  input  logic                  clear_flags,
  output logic [CNT_W-1:0]      last_code,
  output logic [CNT_W-1:0]      avg_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  bubble_seen,
  output logic                  overflow
);

  // The accumulator holds up to 2**AVG_LOG2 counts of at most 2**CNT_W-1,
  // so the group sum never wraps.
  localparam int ACC_W = CNT_W + AVG_LOG2;

  logic [NUM_STAGES-1:0] r_cap;
  logic                  r_cap_v;
  logic                  r_last_v;
  logic [ACC_W-1:0]      r_acc;
  logic [AVG_LOG2-1:0]   r_cnt;
  out_state_e            r_st;
  out_state_e            w_st_next;

  logic [CNT_W-1:0]      w_count;
  logic                  w_bubble;
  logic [ACC_W-1:0]      w_sum;
  logic                  w_done;
  logic [CNT_W-1:0]      w_result;
  logic                  w_load;
  logic                  w_ovf_evt;

  tdc_thermo_count #(
    .NUM_STAGES (NUM_STAGES),
    .CNT_W      (CNT_W)
  ) u_count (
    .word   (r_cap),
    .count  (w_count),
    .bubble (w_bubble)
  );

  // Stage 1: capture the raw TDC word when a sample is offered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap   <= '0;
      r_cap_v <= 1'b0;
    end else begin
      r_cap_v <= sample_valid;
      if (sample_valid) begin
        r_cap <= stage_delays;
      end
    end
  end

  // Stage 2: register the stage count of each captured word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_code <= '0;
      r_last_v  <= 1'b0;
    end else begin
      r_last_v <= r_cap_v;
      if (r_cap_v) begin
        last_code <= w_count;
      end
    end
  end

  // Sticky bubble flag; a new bubble on a clearing edge keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_seen <= 1'b0;
    end else if (r_cap_v && w_bubble) begin
      bubble_seen <= 1'b1;
    end else if (clear_flags) begin
      bubble_seen <= 1'b0;
    end
  end

  // The group completes on the sample that wraps the counter; the divide
  // is a truncating shift, taken as the upper bits of the running sum.
  assign w_sum    = r_acc + ACC_W'(last_code);
  assign w_done   = r_last_v && (r_cnt == '1);
  assign w_result = w_sum[ACC_W-1:AVG_LOG2];

  // Stage 3: accumulate counts, restarting the sum when a group completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_last_v) begin
      r_cnt <= r_cnt + AVG_LOG2'(1);
      r_acc <= w_done ? '0 : w_sum;
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st <= EMPTY;
    end else begin
      r_st <= w_st_next;
    end
  end

  // Output stage next state: a pending result is never overwritten unless
  // the consumer takes it on the same edge; otherwise the new one is dropped.
  always_comb begin
    w_st_next = r_st;
    w_load    = 1'b0;
    w_ovf_evt = 1'b0;
    case (r_st)
      EMPTY: begin
        if (w_done) begin
          w_load    = 1'b1;
          w_st_next = FULL;
        end
      end
      FULL: begin
        if (out_ready && w_done) begin
          w_load = 1'b1;
        end else if (out_ready) begin
          w_st_next = EMPTY;
        end else if (w_done) begin
          w_ovf_evt = 1'b1;
        end
      end
      default: begin
        w_st_next = EMPTY;
      end
    endcase
  end

  // Result register, written only when the output stage takes a result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avg_code <= '0;
    end else if (w_load) begin
      avg_code <= w_result;
    end
  end

  // Sticky overflow flag; a new drop on a clearing edge keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (w_ovf_evt) begin
      overflow <= 1'b1;
    end else if (clear_flags) begin
      overflow <= 1'b0;
    end
  end

  assign out_valid = (r_st == FULL);

endmodule : tdc_thermo_decoder
`default_nettype wire

// File: doc/tdc_thermo_decoder.md
# tdc_thermo_decoder

Downstream consumer of the delay-line TDC: registers the raw `stage_delays` thermometer word, converts it to a binary stage count, flags bubble (non-thermometer) codes, and averages a power-of-two number of samples. Results are offered on a valid/ready interface to the UART reporting path.

## Interface
Parameters:
- `NUM_STAGES`, 10: width of the thermometer input; must match the TDC.
- `AVG_LOG2`, 2: log2 of the number of samples averaged per result; 4 samples at the default.
- `CNT_W`, `$clog2(NUM_STAGES+1)`: count width; 4 at the default. Derived; not to be overridden.

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `stage_delays`  in  NUM_STAGES  TDC thermometer word; bit 0 is the first stage.
- `sample_valid`  in  1  `stage_delays` is to be captured on this edge.
- `clear_flags`  in  1  clears `bubble_seen` and `overflow` on this edge.
- `last_code`  out  CNT_W  count of the most recent sample.
- `avg_code`  out  CNT_W  averaged result; held while `out_valid`.
- `out_valid`  out  1  `avg_code` holds an unconsumed result.
- `out_ready`  in  1  consumer accepts `avg_code` on an edge where `out_valid & out_ready`.
- `bubble_seen`  out  1  sticky: some captured word was not a clean thermometer code.
- `overflow`  out  1  sticky: a completed result was dropped because the previous one was still pending.

## Operation
- Pipeline stage 1: `cap_q <= stage_delays` on an edge with `sample_valid`. `cap_v` is registered alongside.
- Stage 2: when `cap_v` is set, count = popcount(`cap_q`). Bubble = any bit i=1 with bit i-1=0 for i≥1. The count is registered into `last_code`, and `bubble_seen` is set.
- Stage 3: the accumulator (width CNT_W+AVG_LOG2) adds `last_code`. The sample counter (width AVG_LOG2) increments and wraps at 2^AVG_LOG2.
  - On the wrapping sample: `result = (acc + last_code) >> AVG_LOG2` (truncating). The accumulator reloads to 0 and the result goes to the output stage.
- Output FSM `st`:
  - `EMPTY`: a completed result loads `avg_code` and moves to `FULL`.
  - `FULL`: `out_ready` with no new completion moves to `EMPTY`.
    - `out_ready` and a completion on the same edge: load the new result, stay `FULL`, no overflow.
    - Completion without `out_ready`: keep the old `avg_code`, drop the new one, set `overflow`.
  - `out_valid = (st == FULL)`.
- Accumulation continues in both states; there is no backpressure to the TDC.
- Flags: if `clear_flags` and a new bubble or overflow event occur on the same edge, the new event wins and the flag stays 1.
- `reset` low, at any time: `cap_q`, `cap_v`, `last_code`, accumulator, sample counter, `avg_code`, `bubble_seen` and `overflow` go to 0; `st` goes to `EMPTY`. Any partial group is discarded.
  - While reset is low, `sample_valid` is ignored.

## Timing
- `sample_valid` on edge k:
  - `last_code` is valid after edge k+1.
  - If that sample completes a group, `avg_code` and `out_valid` are valid after edge k+2.
- Throughput is one sample per cycle; `sample_valid` may stay high continuously.
- `last_code` updates only on edges where `cap_v` was set; otherwise it holds.
- Output handshake: `avg_code` is stable from `out_valid` rising until the accepting edge.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- `tdc_pkg`:
  - `out_state_e` enum {EMPTY, FULL}.
  - Function `therm_count` (popcount) and function `therm_bubble`, both parameterised by width.
- Sub-module `tdc_thermo_count`: combinational popcount plus bubble detect on `cap_q`. It is instantiated once; stage-2 registers stay in the parent.
- The parent holds the pipeline registers, accumulator, sample counter and output FSM.

## Test plan
Defaults (`NUM_STAGES`=10, `AVG_LOG2`=2) for all scenarios.
- Four consecutive `sample_valid` with `10'b0000000111`:
  - `last_code`=3 after the first sample's edge+1.
  - After the fourth sample's edge+2: `avg_code`=3, `out_valid`=1.
  - `bubble_seen`=0.
- Averaging:
  - Codes 3,4,4,5 → `avg_code`=4.
  - Codes 1,2,2,2 (sum 7) → `avg_code`=1 (truncation).
- Extremes:
  - `10'h3FF` ×4 → `avg_code`=10.
  - `10'h000` ×4 → `avg_code`=0, with `out_valid` still asserted.
- Bubble:
  - `10'b0000001011` → `last_code`=3, `bubble_seen`=1 and held.
  - `clear_flags` pulse → 0.
- Backpressure, with `out_ready`=0 over 8 samples (groups averaging 2 then 6):
  - `avg_code` stays 2 and `overflow`=1.
  - Raise `out_ready` one cycle → `out_valid`=0.
  - A group completing on the accepting edge keeps `out_valid`=1 with the new value.
- Reset mid-group: 2 samples, then `reset`=0 for one cycle:
  - All outputs are 0.
  - The next 4 samples of code 5 → `avg_code`=5 (no residue from the earlier partial group).
